opb_register_ppc2simulink_hs: RTL

- OPB slave register for the PPC-to-fabric direction: the PPC writes a 32-bit word over OPB, and the block presents it to user logic with a valid/ack handshake.
- Provides a read-only status word with a pending flag and a saturating overrun counter, for software flow control.
- Sits on the OPB bus beside the simulink2ppc registers; the user logic runs on OPB_Clk.

---
 rtl/opb_register_ppc2simulink_hs.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/opb_register_ppc2simulink_hs.sv
// OPB slave register, PPC -> fabric direction: a 32-bit data word handed to user
// logic with a valid/ack handshake, plus a read-only pending/overrun status word.

module opb_ppc2sl_byte_lane #(
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    always_ff @(posedge clk) begin
        if (rst)     dout <= INIT;
        else if (we) dout <= din;
    end
endmodule

module opb_register_ppc2simulink_hs #(
    parameter logic [31:0] C_BASEADDR   = 32'h01004700,
    parameter logic [31:0] C_HIGHADDR   = 32'h010047FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter logic [31:0] C_INIT       = 32'h00000000
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [C_OPB_DWIDTH-1:0]   user_data_out,
    output logic                      user_data_valid,
    input  logic                      user_ack
);
    localparam int NUM_LANES = C_OPB_DWIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    typedef struct packed {
        logic                    rnw;
        logic                    status_sel;
        logic [NUM_LANES-1:0]    be;
        logic [C_OPB_DWIDTH-1:0] wdata;
    } opb_req_t;

    state_t                  state, state_d;
    opb_req_t                req_q, req_d;
    logic                    hit;
    logic [C_OPB_AWIDTH-1:0] abus;
    logic [C_OPB_DWIDTH-1:0] data_q;
    logic [C_OPB_DWIDTH-1:0] rd_word;
    logic                    pending;
    logic [15:0]             overrun;
    logic                    in_ack, data_wr, status_wr, user_taken;
    logic                    unused_inputs;

    assign unused_inputs = OPB_seqAddr;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign abus = OPB_ABus;
    assign hit  = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    // Request is latched on the hit edge; the ACK cycle works from this copy.
    always_comb begin
        req_d            = req_q;
        req_d.rnw        = OPB_RNW;
        req_d.status_sel = OPB_ABus[C_OPB_AWIDTH-3];
        req_d.wdata      = OPB_DBus;
        for (int i = 0; i < NUM_LANES; i++) req_d.be[i] = OPB_BE[i];
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst)                      req_q <= '0;
        else if (state == S_IDLE && hit)  req_q <= req_d;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= S_IDLE;
        else         state <= state_d;
    end

    // HOLD gives the master a cycle to drop select so it is not acked twice.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (hit) state_d = S_ACK;
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ack     = (state == S_ACK);
    assign Sl_xferAck = in_ack;
    assign data_wr    = in_ack && !req_q.rnw && !req_q.status_sel && (|req_q.be);
    assign status_wr  = in_ack && !req_q.rnw &&  req_q.status_sel;
    assign user_taken = user_ack && pending;

    // OPB bit 0 is the MSB: overrun lands in OPB bits 0:15, pending in bit 31.
    assign rd_word = req_q.status_sel ? {overrun, {(C_OPB_DWIDTH-17){1'b0}}, pending} : data_q;
    assign Sl_DBus = (in_ack && req_q.rnw) ? rd_word : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        opb_ppc2sl_byte_lane #(
            .INIT (C_INIT[C_OPB_DWIDTH-1-8*i -: 8])
        ) u_lane (
            .clk  (OPB_Clk),
            .rst  (OPB_Rst),
            .we   (data_wr && req_q.be[i]),
            .din  (req_q.wdata[C_OPB_DWIDTH-1-8*i -: 8]),
            .dout (data_q[C_OPB_DWIDTH-1-8*i -: 8])
        );
    end

    // A write landing on the same edge as user_ack wins and is not an overrun.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            pending <= 1'b0;
            overrun <= 16'h0000;
        end else begin
            if (data_wr)         pending <= 1'b1;
            else if (user_taken) pending <= 1'b0;

            if (status_wr)
                overrun <= 16'h0000;
            else if (data_wr && pending && !user_taken && overrun != 16'hFFFF)
                overrun <= overrun + 16'd1;
        end
    end

    assign user_data_out   = data_q;
    assign user_data_valid = pending;
endmodule
